pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of BLOCK.
REQ-002 Parameter BLOCK, default 8, carry-lookahead block width per pipeline stage.
REQ-003 Derived constant STAGES = WIDTH/BLOCK SHALL set the pipeline depth.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand pair valid.
REQ-007 in_ready  out  1  block accepts the operand pair this cycle.
REQ-008 x, y  in  WIDTH  operands (two's complement).
REQ-009 sub  in  1  0: x+y; 1: x-y (y inverted, carry-in 1).
REQ-010 cin  in  1  carry-in; ignored when sub=1.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry out of MSB.
REQ-015 ovf  out  1  signed overflow.

Function
REQ-016 Stage k SHALL compute bits [k*BLOCK +: BLOCK] using generate/propagate lookahead, taking carry from stage k-1's register (stage 0 uses cin or sub).
REQ-017 Unprocessed upper operand bits and completed lower sum bits SHALL travel with each stage's register.
REQ-018 Latency SHALL be exactly STAGES cycles from accepted input to out_valid with no backpressure; throughput one result per cycle.
REQ-019 Each stage SHALL hold a valid bit; stage k SHALL advance when it is empty or stage k+1 advances; last stage advances when out_ready=1 or out_valid=0.
REQ-020 in_ready SHALL equal stage 0's advance condition; bubbles SHALL be absorbed without stalling upstream.
REQ-021 With out_valid=1 and out_ready=0, sum/cout/ovf SHALL be held stable and no result lost or duplicated.
REQ-022 ovf SHALL equal carry into MSB XOR carry out of MSB of the final stage.
REQ-023 Results SHALL emerge in acceptance order.
REQ-024 in_valid with in_ready=0 SHALL have no effect; upstream holds data.

Reset
REQ-025 reset_n low SHALL immediately clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-027 Reset mid-operation SHALL discard all in-flight results; no partial result SHALL appear after reset.

Configuration
REQ-028 Macro PIPE_ADD_SAT_EN defined: input sat (1 bit) SHALL travel with each operation; when sat=1 and ovf=1, sum SHALL clamp to signed max (positive overflow) or signed min (negative overflow); ovf still reported.
REQ-029 Macro undefined: no sat port; sum SHALL always be the wrapped result.

Structure
REQ-030 Package pipe_add_pkg SHALL hold default WIDTH/BLOCK constants and the stage-register struct (valid, partial sum, remaining x/y, carry, sub, sat).
REQ-031 Sub-module cla_block (parameter BLOCK; inputs a, b, c_in; outputs s, c_out, c_msb_in) SHALL be instantiated once per stage via generate.

Verification (WIDTH=32, BLOCK=8, latency 4)
REQ-032 x=0x0000_00FF, y=0x0000_0001, sub=0 -> after 4 cycles sum=0x0000_0100, cout=0, ovf=0.
REQ-033 x=0x7FFF_FFFF, y=1, sub=0 -> sum=0x8000_0000, ovf=1, cout=0; with PIPE_ADD_SAT_EN and sat=1 -> sum=0x7FFF_FFFF, ovf=1.
REQ-034 x=5, y=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; x=0xFFFF_FFFF, y=1, sub=0 -> sum=0, cout=1.
REQ-035 Back-to-back 8 inputs, out_ready low cycles 6-9 -> in_ready drops once pipeline full, all 8 results in order, held stable while stalled.
REQ-036 reset_n pulsed low with 3 ops in flight -> out_valid=0 immediately, no stale result afterwards, in_ready=1 next cycle.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and the per-stage pipeline record for pipelined_cla_adder.
// Optional build macro: PIPE_ADD_SAT_EN adds a per-operation saturate flag.
package pipe_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  // One pipeline stage register. Sized for DEF_WIDTH; the adder's WIDTH
  // must not exceed it. x/y hold the not-yet-added upper operand bits,
  // sum holds the lower bits completed so far.
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] x;
    logic [DEF_WIDTH-1:0] y;
    logic                 c;     // carry into the next block
    logic                 cmsb;  // carry into the MSB of the last block added
    logic                 sub;
`ifdef PIPE_ADD_SAT_EN
    logic                 sat;
`endif
  } stage_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// Optional build macro: PIPE_ADD_SAT_EN adds the sat request bit.
interface pipelined_cla_adder_if
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             cin;
`ifdef PIPE_ADD_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef PIPE_ADD_SAT_EN
  modport master (output in_valid, x, y, sub, cin, sat, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, x, y, sub, cin, sat, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, x, y, sub, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, x, y, sub, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif

endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// BLOCK-bit carry-lookahead adder slice used by every pipeline stage.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry from the group generate/propagate of bits [i:0] and c_in
  always_comb begin
    logic gg, pp;
    gg   = 1'b0;
    pp   = 1'b1;
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < BLOCK; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & c_in);
    end
  end

  assign s        = p ^ c[BLOCK-1:0];
  assign c_out    = c[BLOCK];
  assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice per stage,
// valid/ready handshake with per-stage stall, results in acceptance order.
// Optional build macro: PIPE_ADD_SAT_EN clamps overflowed results when sat=1.
module pipelined_cla_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input logic                  clock,
  input logic                  reset_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int STAGES = WIDTH / BLOCK;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           prev, nxt, st;
    logic [BLOCK-1:0] b, s;
    logic             co, cm;
    logic             adv;

    if (k == 0) begin : g_first
      // Stage 0 takes the operand pair straight from the bus
      always_comb begin
        prev              = '0;
        prev.vld          = bus.in_valid;
        prev.x[WIDTH-1:0] = bus.x;
        prev.y[WIDTH-1:0] = bus.y;
        prev.sub          = bus.sub;
        prev.c            = bus.sub | bus.cin;
`ifdef PIPE_ADD_SAT_EN
        prev.sat          = bus.sat;
`endif
      end
    end else begin : g_next
      assign prev = g_stage[k-1].st;
    end

    // Subtraction inverts y; the +1 rides in on stage 0's carry
    assign b = prev.sub ? ~prev.y[k*BLOCK +: BLOCK] : prev.y[k*BLOCK +: BLOCK];

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a        (prev.x[k*BLOCK +: BLOCK]),
      .b        (b),
      .c_in     (prev.c),
      .s        (s),
      .c_out    (co),
      .c_msb_in (cm)
    );

    // Merge this slice into the travelling record
    always_comb begin
      nxt                        = prev;
      nxt.sum[k*BLOCK +: BLOCK]  = s;
      nxt.c                      = co;
      nxt.cmsb                   = cm;
    end

    // A stage moves when it is empty or its successor moves
    if (k == STAGES - 1) begin : g_adv_last
      assign adv = !st.vld || bus.out_ready;
    end else begin : g_adv_mid
      assign adv = !st.vld || g_stage[k+1].adv;
    end

    // Stage register; reset drops everything in flight
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  st <= '0;
      else if (adv)  st <= nxt;
    end
  end

  stage_t           lst;
  logic             ovf_w;
  logic [WIDTH-1:0] sum_w;
  logic             unused_lst;

  assign lst        = g_stage[STAGES-1].st;
  assign ovf_w      = lst.c ^ lst.cmsb;
  assign unused_lst = ^{lst.x, lst.y, lst.sub};

  // Final result, optionally clamped to the signed limit on overflow
  always_comb begin
    sum_w = lst.sum[WIDTH-1:0];
`ifdef PIPE_ADD_SAT_EN
    // Wrapped MSB=1 means positive overflow -> max, else min
    if (lst.sat && ovf_w)
      sum_w = {~lst.sum[WIDTH-1], {(WIDTH-1){lst.sum[WIDTH-1]}}};
`endif
  end

  assign bus.in_ready  = g_stage[0].adv;
  assign bus.out_valid = lst.vld;
  assign bus.sum       = sum_w;
  assign bus.cout      = lst.c;
  assign bus.ovf       = ovf_w;

endmodule
